// File: rtl/seg_serial_ctrl.sv
// Serial sequencer for the 8-digit 7-segment 74HC595 chain, plus the decoder blink enable.
// Optional SEG_AUTO_REFRESH_EN: periodic and on-change frame re-send from IDLE.
//
// state | meaning
// IDLE  | waiting for a start request
// SHIFT | clocking 64 shadow bits out, MSB first
// LATCH | pulsing s_lat to move the chain into the storage registers
module seg_serial_ctrl #(
  parameter int CLK_DIV    = 2,
`ifdef SEG_AUTO_REFRESH_EN
  parameter int REFRESH    = 1024,
`endif
  parameter int FLASH_BITS = 25
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [63:0] SEG_TXT,
  output logic        s_clk,
  output logic        s_data,
  output logic        s_lat,
  output logic        s_clrn,
  output logic        busy,
  output logic        done,
  output logic        flash
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  state_t                state;
  logic [63:0]           shadow;
  logic [5:0]            bit_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [FLASH_BITS-1:0] flash_cnt;
  logic                  go;

`ifdef SEG_AUTO_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH + 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH - 1);

  logic [REF_W-1:0] idle_cnt;
  logic             auto_start;

  assign auto_start = (idle_cnt == REF_LAST) || (SEG_TXT != shadow);
  assign go = (state == IDLE) && (start || auto_start);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      idle_cnt <= '0;
    else if (state != IDLE || go)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign go = (state == IDLE) && start;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      flash_cnt <= '0;
    else
      flash_cnt <= flash_cnt + 1'b1;
  end

  assign flash = flash_cnt[FLASH_BITS-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      shadow  <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      s_clk   <= 1'b0;
      s_data  <= 1'b0;
      s_lat   <= 1'b0;
      s_clrn  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      s_clrn <= 1'b1;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            shadow  <= SEG_TXT;
            s_data  <= SEG_TXT[63];
            s_clk   <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= 6'd63;
            div_cnt <= DIV_LOAD;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_LOAD;
            if (!s_clk) begin
              s_clk <= 1'b1;
            end else if (bit_cnt == 6'd0) begin
              s_clk  <= 1'b0;
              s_data <= 1'b0;
              s_lat  <= 1'b1;
              state  <= LATCH;
            end else begin
              // data only moves on the falling half so the 595 samples a settled bit
              s_clk   <= 1'b0;
              s_data  <= shadow[bit_cnt - 6'd1];
              bit_cnt <= bit_cnt - 6'd1;
            end
          end
        end
        LATCH: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            s_lat <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serial_ctrl.sv
// Directed bench for seg_serial_ctrl: frame timing, shadowing, back-to-back, reset, blink.
module tb_seg_serial_ctrl;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [63:0] SEG_TXT;
  logic        s_clk;
  logic        s_data;
  logic        s_lat;
  logic        s_clrn;
  logic        busy;
  logic        done;
  logic        flash;

  int n_chk;
  int n_err;

  seg_serial_ctrl #(.CLK_DIV(2), .FLASH_BITS(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .SEG_TXT (SEG_TXT),
    .s_clk   (s_clk),
    .s_data  (s_data),
    .s_lat   (s_lat),
    .s_clrn  (s_clrn),
    .busy    (busy),
    .done    (done),
    .flash   (flash)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One start pulse, 259 observed cycles; optionally zero SEG_TXT at cycle chg_at.
  task automatic run_frame(input string tag, input logic [63:0] pat, input int chg_at);
    logic [63:0] word;
    int rises, lat_first, lat_last, lat_cnt, done_cnt, done_k, glitch;
    logic prev_clk, prev_data;
    word = '0; rises = 0; lat_first = 0; lat_last = 0; lat_cnt = 0;
    done_cnt = 0; done_k = 0; glitch = 0;
    SEG_TXT = pat;
    start = 1'b1;
    prev_clk = s_clk;
    prev_data = s_data;
    for (int k = 1; k <= 259; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk({tag, "_busy_entry"}, busy, 1'b1);
      end
      if (s_clk && !prev_clk) begin
        word = {word[62:0], s_data};
        rises++;
      end
      if (k > 1 && s_data !== prev_data && !(prev_clk && !s_clk)) glitch++;
      if (s_lat) begin
        if (lat_cnt == 0) lat_first = k;
        lat_last = k;
        lat_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      prev_clk = s_clk;
      prev_data = s_data;
      if (k == chg_at) SEG_TXT = '0;
    end
    chk({tag, "_rises"}, rises, 64);
    chk({tag, "_word"}, word, pat);
    chk({tag, "_lat_first"}, lat_first, 257);
    chk({tag, "_lat_last"}, lat_last, 258);
    chk({tag, "_lat_cnt"}, lat_cnt, 2);
    chk({tag, "_done_k"}, done_k, 259);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_data_glitch"}, glitch, 0);
    chk({tag, "_busy_end"}, busy, 1'b0);
    @(negedge clk);
    chk({tag, "_done_after"}, done, 1'b0);
    chk({tag, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int flash_bad;
    int d_first, d_second, d_third, d_cnt, b2b_rises, busy_bad, stray;
    logic prev_clk;
    n_chk = 0;
    n_err = 0;
    rstn = 1'b0;
    start = 1'b0;
    SEG_TXT = '0;

    repeat (3) @(negedge clk);
    chk("rst_outputs", {s_clk, s_data, s_lat, s_clrn, busy, done, flash}, 7'b0);

    rstn = 1'b1;
    flash_bad = 0;
    for (int j = 0; j < 32; j++) begin
      #1;
      if (flash !== ((j % 16) >= 8)) flash_bad++;
      if (j == 0) chk("clrn_before_clk", s_clrn, 1'b0);
      if (j == 1) chk("clrn_after_clk", s_clrn, 1'b1);
      @(negedge clk);
    end
    chk("flash_pattern", flash_bad, 0);

    run_frame("msb_lsb", 64'h8000_0000_0000_0001, 0);
    run_frame("a5_shadow", 64'hA5A5_A5A5_A5A5_A5A5, 10);

    // start held high: frames chain, done every 259 cycles
    SEG_TXT = 64'h0123_4567_89AB_CDEF;
    start = 1'b1;
    d_first = 0; d_second = 0; d_third = 0; d_cnt = 0; b2b_rises = 0; busy_bad = 0;
    prev_clk = s_clk;
    for (int k = 1; k <= 777; k++) begin
      @(negedge clk);
      if (s_clk && !prev_clk) b2b_rises++;
      prev_clk = s_clk;
      if (done) begin
        d_cnt++;
        if (d_cnt == 1) d_first = k;
        if (d_cnt == 2) d_second = k;
        if (d_cnt == 3) d_third = k;
      end
      if (!busy && !done) busy_bad++;
      if (k == 777) start = 1'b0;
    end
    chk("b2b_done1", d_first, 259);
    chk("b2b_done2", d_second, 518);
    chk("b2b_done3", d_third, 777);
    chk("b2b_done_cnt", d_cnt, 3);
    chk("b2b_rises", b2b_rises, 192);
    chk("b2b_busy_gap", busy_bad, 0);
    @(negedge clk);
    chk("b2b_stop", busy, 1'b0);

    // reset in the middle of SHIFT
    SEG_TXT = 64'hFFFF_0000_FFFF_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_busy_before", busy, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_outputs", {s_clk, s_data, s_lat, s_clrn, busy, done, flash}, 7'b0);
    @(negedge clk);
    rstn = 1'b1;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy || s_lat) stray++;
    end
    chk("mid_no_done", stray, 0);

    run_frame("post_rst", 64'hDEAD_BEEF_1357_9BDF, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
